// File: rtl/flush_sequencer.sv
// Cache-flush sequencer: gathers L1 flush completions, then issues one L2 flush per round.
// Optional build macro FLUSH_TIMEOUT_EN adds a sticky per-phase timeout flag.
module flush_sequencer #(
  parameter int N_L1  = 2,
  parameter int CNT_W = 64,
  parameter int TMO_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_L1-1:0]  l1_flush_req,
  input  logic [N_L1-1:0]  l1_flush_complete,
  output logic             l2_flush_req,
  input  logic             l2_flush_complete,
  output logic             in_flush_mode,
  output logic             flush_done,
  output logic [N_L1-1:0]  pending_mask,
  output logic [CNT_W-1:0] round_count,
  output logic             flush_timeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_L1  = 2'd1,
    FLUSH_L2 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [N_L1-1:0] pending, pending_nxt;
  logic [N_L1-1:0] deferred, deferred_nxt;
  logic            l2_req_nxt;
  logic            done_nxt;
  logic            l2_done_seen;

  // The L2 completion is only honoured once the request pulse has gone out.
  assign l2_done_seen = (state == FLUSH_L2) && l2_flush_complete && !l2_flush_req;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    deferred_nxt = deferred;
    l2_req_nxt   = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if ((l1_flush_req | deferred) != '0) begin
          pending_nxt  = l1_flush_req | deferred;
          deferred_nxt = '0;
          state_nxt    = WAIT_L1;
        end
      end
      WAIT_L1: begin
        deferred_nxt = deferred | (l1_flush_req & ~pending);
        pending_nxt  = pending & ~l1_flush_complete;
        if (pending_nxt == '0) begin
          l2_req_nxt = 1'b1;
          state_nxt  = FLUSH_L2;
        end
      end
      FLUSH_L2: begin
        deferred_nxt = deferred | l1_flush_req;
        if (l2_done_seen) begin
          done_nxt = 1'b1;
          if (deferred_nxt != '0) begin
            // Queued requests chain straight into the next round, no idle gap.
            pending_nxt  = deferred_nxt;
            deferred_nxt = '0;
            state_nxt    = WAIT_L1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        pending_nxt  = '0;
        deferred_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      deferred     <= '0;
      l2_flush_req <= 1'b0;
      flush_done   <= 1'b0;
      round_count  <= '0;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      deferred     <= deferred_nxt;
      l2_flush_req <= l2_req_nxt;
      flush_done   <= done_nxt;
      if (done_nxt) round_count <= round_count + CNT_W'(1);
    end
  end

  assign in_flush_mode = (state != IDLE);
  assign pending_mask  = pending;

`ifdef FLUSH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;

  // Flag only; the sequencer keeps waiting for the real completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state_nxt != state) tmo_cnt <= '0;
      else if (state != IDLE) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if ((state != IDLE) && (&tmo_cnt) && !tmo_flag) begin
        tmo_flag <= 1'b1;
        $display("flush_sequencer: flush timeout in state %s", state.name());
      end
    end
  end

  assign flush_timeout = tmo_flag;
`else
  assign flush_timeout = 1'b0;
`endif

endmodule

// File: doc/flush_sequencer.md
Name: flush_sequencer

Overview:
- Generalised cache-flush sequencer for the core/L1/L2 wrapper.
- Accepts flush requests from N_L1 first-level caches (L1I, L1D, future L1s) and waits for every requesting L1 to report completion, in any order.
- Then issues a single L2 flush and holds `in_flush_mode` high until the L2 reports done.
- Requests that arrive mid-flush are queued for a follow-on round. The block also keeps a round counter.

Parameters:
- N_L1, 2, number of L1 flush channels (minimum 1).
- CNT_W, 64, width of the completed-round statistic counter.
- TMO_W, 20, width of the per-phase timeout counter (used only with FLUSH_TIMEOUT_EN).

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- l1_flush_req  input  N_L1  per-L1 flush request, one bit per channel, sampled every cycle
- l1_flush_complete  input  N_L1  per-L1 completion pulse
- l2_flush_req  output  1  one-cycle pulse that starts the L2 flush
- l2_flush_complete  input  1  L2 completion pulse
- in_flush_mode  output  1  high from the cycle after the first request until the cycle after the final L2 completion
- flush_done  output  1  one-cycle pulse when a round ends
- pending_mask  output  N_L1  L1 channels still awaited in the current round
- round_count  output  CNT_W  number of completed rounds
- flush_timeout  output  1  sticky timeout flag (tied 0 without FLUSH_TIMEOUT_EN)

Behaviour:
- Reset values: all outputs 0; state IDLE; pending and deferred masks 0. Reset mid-round aborts the round with no l2_flush_req and no flush_done.
- States: IDLE, WAIT_L1, FLUSH_L2.
- IDLE:
  - If (l1_flush_req | deferred) != 0, load pending = l1_flush_req | deferred, clear deferred, go to WAIT_L1, and set in_flush_mode next cycle.
  - l1_flush_complete is ignored in IDLE.
- WAIT_L1: each cycle, pending <= pending & ~l1_flush_complete.
  - Completions on non-pending bits are ignored.
  - Simultaneous completions on several channels clear together.
  - When the cleared value is 0: l2_flush_req = 1 for exactly one cycle (the transition cycle's next edge) and state becomes FLUSH_L2. Latency is 1 cycle from the last L1 completion to the l2_flush_req pulse.
- FLUSH_L2:
  - On l2_flush_complete: flush_done pulses the next cycle, round_count increments (wraps at 2^CNT_W), and state returns to IDLE.
  - in_flush_mode drops in that same cycle, unless deferred != 0. In that case the next round starts directly: state goes to WAIT_L1, pending = deferred, and in_flush_mode stays 1 with no gap.
  - l2_flush_complete asserted in the same cycle as l2_flush_req is ignored; it is only sampled while in FLUSH_L2.
- Deferred requests: in WAIT_L1 or FLUSH_L2, deferred |= l1_flush_req & ~pending. A request on an already-pending channel is merged and not re-queued.
- pending_mask reflects the registered pending value. It is 0 in IDLE and FLUSH_L2.

Optional Feature:
- Macro: FLUSH_TIMEOUT_EN.
- When defined:
  - A TMO_W-bit counter clears on every state change and increments each cycle in WAIT_L1 or FLUSH_L2.
  - When it reaches all-ones, flush_timeout sets and stays set until reset.
  - The state machine continues waiting and is not forced forward.
  - A $display message is issued once when the flag sets.
- When undefined: no counter logic is built and flush_timeout is tied to 0.

Test Plan:
- N_L1=2; l1_flush_req=2'b11 at cycle 0; complete[0] at cycle 3, complete[1] at cycle 6 -> l2_flush_req pulses at cycle 7; l2_flush_complete at cycle 10 -> flush_done at cycle 11, in_flush_mode low at cycle 11, round_count=1.
- l1_flush_req=2'b10 only -> pending_mask=2'b10; a complete[0] pulse is ignored; complete[1] -> l2_flush_req on the next cycle.
- Both completions in the same cycle -> single l2_flush_req pulse one cycle later; pending_mask 2'b11 -> 2'b00.
- N_L1=4; req=4'b0011, then req=4'b0100 during FLUSH_L2 -> after L2 completes, pending=4'b0100 with no in_flush_mode gap; second l2_flush_req after complete[2]; round_count=2.
- Assert reset while in WAIT_L1 with pending=2'b01 -> all outputs 0 next cycle; no spurious l2_flush_req; a new request is accepted afterwards.
- FLUSH_TIMEOUT_EN with TMO_W=4; request and withhold completion for 16 cycles -> flush_timeout=1 and stays 1; a later completion still finishes the round.
